// File: rtl/aes_pkg.sv
// Shared AES types, the round-constant table and the RotWord helper used by the
// key schedule. Key bytes are held as a 4x4 matrix indexed [row][column].
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t state_t [0:3][0:3];
    typedef logic [0:3][7:0] word_t;

    localparam int AES128_ROUNDS = 10;

    localparam byte_t RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } fsm_t;

    function automatic word_t rot_word(input word_t w);
        return {w[1], w[2], w[3], w[0]};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Handshake bundle between the key-schedule block and its key loader / round-key consumer.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic       start;
    state_t     key_in;
    logic       start_ready;
    logic       rk_valid;
    logic       rk_ready;
    state_t     rk_out;
    logic [3:0] rk_round;
    logic       rk_last;

    modport master (
        output start, key_in, rk_ready,
        input  start_ready, rk_valid, rk_out, rk_round, rk_last
    );

    modport slave (
        input  start, key_in, rk_ready,
        output start_ready, rk_valid, rk_out, rk_round, rk_last
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, looked up from a flat 256-entry constant.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key and emits one round key per
// valid/ready handshake, straight from flops, for the AddRoundKey stage.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_expand_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    fsm_t       state_q, state_d;
    state_t     rk_out_q, rk_out_d;
    logic [3:0] rk_round_q, rk_round_d;
    logic       rk_valid_q, rk_valid_d;
    logic       rk_last_q, rk_last_d;
    logic       start_ready_q, start_ready_d;

    word_t      rot_s;
    byte_t      sub_s [0:3];
    byte_t      temp_s [0:3];
    byte_t      rcon_s;
    state_t     next_key_s;

    assign rot_s = rot_word({rk_out_q[0][3], rk_out_q[1][3], rk_out_q[2][3], rk_out_q[3][3]});

    for (genvar r = 0; r < 4; r++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_s[r]),
            .out_byte (sub_s[r])
        );
    end

    // Next round key: SubWord(RotWord(c3)) ^ RCON feeds a running XOR across the columns
    always_comb begin
        rcon_s     = 8'h00;
        next_key_s = rk_out_q;
        if (rk_round_q < 4'd10) begin
            rcon_s = RCON[rk_round_q];
        end else begin
            rcon_s = 8'h00;
        end
        for (int r = 0; r < 4; r++) begin
            temp_s[r]        = (r == 0) ? (sub_s[r] ^ rcon_s) : sub_s[r];
            next_key_s[r][0] = rk_out_q[r][0] ^ temp_s[r];
            next_key_s[r][1] = rk_out_q[r][1] ^ next_key_s[r][0];
            next_key_s[r][2] = rk_out_q[r][2] ^ next_key_s[r][1];
            next_key_s[r][3] = rk_out_q[r][3] ^ next_key_s[r][2];
        end
    end

    // Schedule FSM: load on start, advance on each handshake, return to IDLE after the last key
    always_comb begin
        state_d       = state_q;
        rk_out_d      = rk_out_q;
        rk_round_d    = rk_round_q;
        rk_valid_d    = rk_valid_q;
        rk_last_d     = rk_last_q;
        start_ready_d = start_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && start_ready_q) begin
                    state_d       = ST_EMIT;
                    rk_out_d      = bus.key_in;
                    rk_round_d    = 4'd0;
                    rk_valid_d    = 1'b1;
                    rk_last_d     = 1'b0;
                    start_ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (bus.rk_ready) begin
                    if (rk_round_q == LAST_ROUND) begin
                        state_d       = ST_IDLE;
                        rk_valid_d    = 1'b0;
                        rk_last_d     = 1'b0;
                        start_ready_d = 1'b1;
                    end else begin
                        rk_out_d   = next_key_s;
                        rk_round_d = rk_round_q + 4'd1;
                        rk_last_d  = ((rk_round_q + 4'd1) == LAST_ROUND);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                rk_valid_d    = 1'b0;
                rk_last_d     = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset discards any partial schedule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rk_out_q      <= '{default: '{default: 8'h00}};
            rk_round_q    <= 4'd0;
            rk_valid_q    <= 1'b0;
            rk_last_q     <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            rk_out_q      <= rk_out_d;
            rk_round_q    <= rk_round_d;
            rk_valid_q    <= rk_valid_d;
            rk_last_q     <= rk_last_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign bus.rk_out      = rk_out_q;
    assign bus.rk_round    = rk_round_q;
    assign bus.rk_valid    = rk_valid_q;
    assign bus.rk_last     = rk_last_q;
    assign bus.start_ready = start_ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero schedules, backpressure,
// start while busy, asynchronous reset mid-schedule and back-to-back schedules.
module tb_aes_key_expand;
    import aes_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    logic [127:0] rk_flat;
    logic [127:0] fips_rk [0:10];

    aes_key_expand_if bus ();

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS byte i sits at [i%4][i/4]
    always_comb begin
        rk_flat = '0;
        for (int i = 0; i < 16; i++) begin
            rk_flat[127 - 8*i -: 8] = bus.rk_out[i % 4][i / 4];
        end
    end

    task automatic set_key(input logic [127:0] k);
        for (int i = 0; i < 16; i++) begin
            bus.key_in[i % 4][i / 4] = k[127 - 8*i -: 8];
        end
    endtask

    task automatic drain();
        bus.rk_ready = 1'b1;
        for (int k = 0; k < 20 && bus.rk_valid === 1'b1; k++) @(negedge clk);
        bus.rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.rk_valid); end
        tests_run++; if (bus.start_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready); end
        tests_run++; if (bus.rk_round !== 4'd0) begin tests_failed++; $display("FAIL reset_round got=%0d exp=0", bus.rk_round); end
        tests_run++; if (bus.rk_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got=%b exp=0", bus.rk_last); end
        tests_run++; if (rk_flat !== 128'h0) begin tests_failed++; $display("FAIL reset_rk_out got=%h exp=0", rk_flat); end
    endtask

    task automatic test_fips();
        bus.rk_ready = 1'b1;
        @(negedge clk); set_key(fips_rk[0]); bus.start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); bus.start = 1'b0;
            tests_run++; if (bus.rk_valid !== 1'b1) begin tests_failed++; $display("FAIL fips_valid r%0d got=%b exp=1", i, bus.rk_valid); end
            tests_run++; if (bus.rk_round !== 4'(i)) begin tests_failed++; $display("FAIL fips_round got=%0d exp=%0d", bus.rk_round, i); end
            tests_run++; if (rk_flat !== fips_rk[i]) begin tests_failed++; $display("FAIL fips_key r%0d got=%h exp=%h", i, rk_flat, fips_rk[i]); end
            tests_run++; if (bus.rk_last !== 1'(i == 10)) begin tests_failed++; $display("FAIL fips_last r%0d got=%b exp=%b", i, bus.rk_last, (i == 10)); end
            tests_run++; if (bus.start_ready !== 1'b0) begin tests_failed++; $display("FAIL fips_start_ready r%0d got=%b exp=0", i, bus.start_ready); end
        end
        @(negedge clk);
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL fips_done_valid got=%b exp=0", bus.rk_valid); end
        tests_run++; if (bus.start_ready !== 1'b1) begin tests_failed++; $display("FAIL fips_done_ready got=%b exp=1", bus.start_ready); end
        bus.rk_ready = 1'b0;
    endtask

    task automatic test_zero_key();
        bus.rk_ready = 1'b1;
        @(negedge clk); set_key(128'h0); bus.start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); bus.start = 1'b0;
            if (i == 1) begin
                tests_run++; if (rk_flat !== 128'h62636363626363636263636362636363) begin tests_failed++; $display("FAIL zero_r1 got=%h exp=62636363626363636263636362636363", rk_flat); end
            end
            if (i == 10) begin
                tests_run++; if (rk_flat !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin tests_failed++; $display("FAIL zero_r10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", rk_flat); end
                tests_run++; if (bus.rk_last !== 1'b1) begin tests_failed++; $display("FAIL zero_last got=%b exp=1", bus.rk_last); end
            end
        end
        @(negedge clk);
        bus.rk_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int           idx;
        int           cyc;
        int           stalls;
        logic         stalled;
        logic [127:0] prev_flat;
        logic [3:0]   prev_round;
        idx = 0; cyc = 0; stalls = 0; stalled = 1'b0; prev_flat = '0; prev_round = 4'd0;
        bus.rk_ready = 1'b0;
        @(negedge clk); set_key(fips_rk[0]); bus.start = 1'b1;
        while (idx < 11 && cyc < 400) begin
            @(negedge clk); bus.start = 1'b0; cyc++;
            tests_run++; if (bus.rk_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid got=%b exp=1", bus.rk_valid); end
            if (stalled) begin
                tests_run++; if (rk_flat !== prev_flat || bus.rk_round !== prev_round) begin tests_failed++; $display("FAIL bp_stable got=%h/%0d exp=%h/%0d", rk_flat, bus.rk_round, prev_flat, prev_round); end
            end
            tests_run++; if (bus.rk_round !== 4'(idx)) begin tests_failed++; $display("FAIL bp_round got=%0d exp=%0d", bus.rk_round, idx); end
            tests_run++; if (rk_flat !== fips_rk[idx]) begin tests_failed++; $display("FAIL bp_key r%0d got=%h exp=%h", idx, rk_flat, fips_rk[idx]); end
            tests_run++; if (bus.rk_last !== 1'(idx == 10)) begin tests_failed++; $display("FAIL bp_last r%0d got=%b exp=%b", idx, bus.rk_last, (idx == 10)); end
            prev_flat  = rk_flat;
            prev_round = bus.rk_round;
            bus.rk_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            stalled = ~bus.rk_ready;
            if (stalled) stalls++;
            if (bus.rk_ready) idx++;
        end
        tests_run++; if (idx != 11) begin tests_failed++; $display("FAIL bp_timeout keys=%0d exp=11", idx); end
        @(negedge clk);
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_done_valid got=%b exp=0", bus.rk_valid); end
        bus.rk_ready = 1'b0;
        $display("[TB] backpressure stall cycles: %0d", stalls);
    endtask

    task automatic test_start_busy();
        bus.rk_ready = 1'b1;
        @(negedge clk); set_key(fips_rk[0]); bus.start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); bus.start = 1'b0;
            tests_run++; if (rk_flat !== fips_rk[i]) begin tests_failed++; $display("FAIL busy_key r%0d got=%h exp=%h", i, rk_flat, fips_rk[i]); end
            tests_run++; if (bus.start_ready !== 1'b0) begin tests_failed++; $display("FAIL busy_start_ready r%0d got=%b exp=0", i, bus.start_ready); end
            if (i == 4) begin
                set_key(128'hffeeddccbbaa99887766554433221100); bus.start = 1'b1;
            end
            if (i == 10) begin
                bus.start = 1'b1;
            end
        end
        @(negedge clk); bus.start = 1'b0;
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL busy_final_start_valid got=%b exp=0", bus.rk_valid); end
        tests_run++; if (bus.start_ready !== 1'b1) begin tests_failed++; $display("FAIL busy_final_ready got=%b exp=1", bus.start_ready); end
        @(negedge clk);
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL busy_idle_valid got=%b exp=0", bus.rk_valid); end
        bus.rk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.rk_ready = 1'b1;
        @(negedge clk); set_key(fips_rk[0]); bus.start = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk); bus.start = 1'b0;
        end
        bus.rk_ready = 1'b0;
        tests_run++; if (bus.rk_round !== 4'd6) begin tests_failed++; $display("FAIL rst_pre_round got=%0d exp=6", bus.rk_round); end
        #3 rst_n = 1'b0;
        #1;
        tests_run++; if (bus.rk_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid got=%b exp=0", bus.rk_valid); end
        tests_run++; if (rk_flat !== 128'h0) begin tests_failed++; $display("FAIL rst_mid_rk_out got=%h exp=0", rk_flat); end
        tests_run++; if (bus.rk_round !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_round got=%0d exp=0", bus.rk_round); end
        tests_run++; if (bus.start_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready got=%b exp=1", bus.start_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); set_key(fips_rk[0]); bus.start = 1'b1; bus.rk_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        tests_run++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd0) begin tests_failed++; $display("FAIL rst_restart_r0 got=%b/%0d exp=1/0", bus.rk_valid, bus.rk_round); end
        tests_run++; if (rk_flat !== fips_rk[0]) begin tests_failed++; $display("FAIL rst_restart_key0 got=%h exp=%h", rk_flat, fips_rk[0]); end
        @(negedge clk);
        tests_run++; if (rk_flat !== fips_rk[1]) begin tests_failed++; $display("FAIL rst_restart_key1 got=%h exp=%h", rk_flat, fips_rk[1]); end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.rk_ready = 1'b1;
        @(negedge clk); set_key(128'h0); bus.start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); bus.start = 1'b0;
        end
        @(negedge clk);
        tests_run++; if (bus.start_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got=%b exp=1", bus.start_ready); end
        set_key(fips_rk[0]); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        tests_run++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd0) begin tests_failed++; $display("FAIL b2b_r0 got=%b/%0d exp=1/0", bus.rk_valid, bus.rk_round); end
        tests_run++; if (rk_flat !== fips_rk[0]) begin tests_failed++; $display("FAIL b2b_key0 got=%h exp=%h", rk_flat, fips_rk[0]); end
        drain();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.rk_ready = 1'b0;
        set_key(128'h0);
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);

        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
